// File: rtl/alu_src_b_stage_if.sv
// ALU B-operand stage bus: control/datapath requests on one side,
// registered operand and status on the other.
interface alu_src_b_stage_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
);
    logic [2:0]       ALUSrcB;
    logic             load;
    logic [WIDTH-1:0] B;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] mem_data;
    logic             mem_valid;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             busy;
    logic             err;

    modport master (
        output ALUSrcB, load, B, imm, mem_data, mem_valid,
        input  data_out, out_valid, busy, err
    );

    modport slave (
        input  ALUSrcB, load, B, imm, mem_data, mem_valid,
        output data_out, out_valid, busy, err
    );
endinterface

// File: rtl/alu_src_b_stage.sv
// Registered ALU B-operand select with a bounded wait for memory-sourced
// operands; every output comes straight from a flop.
module alu_src_b_stage #(
    parameter int WIDTH       = 32,
    parameter int IMM_W       = 16,
    parameter int SHIFT       = 2,
    parameter int CONST_VAL   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input logic              clk,
    input logic              reset,
    alu_src_b_stage_if.slave bus
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    typedef enum logic [2:0] {
        SEL_B     = 3'b000,
        SEL_CONST = 3'b001,
        SEL_SHIMM = 3'b010,
        SEL_SEXT  = 3'b011,
        SEL_MEM   = 3'b100
    } sel_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_err;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_data_next;
    logic             w_out_valid_next;
    logic             w_busy_next;
    logic             w_err_next;

    logic [WIDTH-1:0] w_sext;
    logic [WIDTH-1:0] w_sext_shl;
    logic [WIDTH-1:0] w_const;
    logic [WIDTH-1:0] w_operand;
    logic             w_sel_legal;
    logic             w_sel_mem;

    assign w_sext     = {{(WIDTH - IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    assign w_sext_shl = w_sext << SHIFT;
    assign w_const    = WIDTH'(CONST_VAL);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_operand   = bus.B;
        w_sel_legal = 1'b1;
        w_sel_mem   = 1'b0;
        case (bus.ALUSrcB)
            SEL_B:     w_operand = bus.B;
            SEL_CONST: w_operand = w_const;
            SEL_SHIMM: w_operand = w_sext_shl;
            SEL_SEXT:  w_operand = w_sext;
            SEL_MEM:   w_sel_mem = 1'b1;
            default:   w_sel_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_data_next      = r_data_out;
        w_out_valid_next = 1'b0;
        w_err_next       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load) begin
                    if (!w_sel_legal) begin
                        w_err_next = 1'b1;
                    end else if (w_sel_mem) begin
                        if (bus.mem_valid) begin
                            w_data_next      = bus.mem_data;
                            w_out_valid_next = 1'b1;
                        end else begin
                            w_state_next = WAIT_MEM;
                            w_cnt_next   = '0;
                        end
                    end else begin
                        w_data_next      = w_operand;
                        w_out_valid_next = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // mem_valid is checked first so it beats a timeout on the same edge
                if (bus.mem_valid) begin
                    w_data_next      = bus.mem_data;
                    w_out_valid_next = 1'b1;
                    w_state_next     = IDLE;
                    w_cnt_next       = '0;
                end else if ((MEM_TIMEOUT != 0) && (w_cnt_inc == CNT_W'(MEM_TIMEOUT))) begin
                    w_err_next   = 1'b1;
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_busy_next = (w_state_next == WAIT_MEM);

    // NOTE: state flops use non-blocking assignments so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_data_out  <= w_data_next;
            r_out_valid <= w_out_valid_next;
            r_busy      <= w_busy_next;
            r_err       <= w_err_next;
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
endmodule

// File: doc/alu_src_b_stage.md
# alu_src_b_stage

Registered, parametrised ALU B-operand stage for the multicycle datapath. Selects the ALU B operand from register B, a constant, the sign-extended immediate (plain or shifted), or memory data, and captures it into an output register on request. Memory-sourced operands are handled with a valid handshake and a bounded wait, so the control unit can issue the load before memory data is ready.

## Interface
- WIDTH, 32, operand width; WIDTH > IMM_W
- IMM_W, 16, immediate field width
- SHIFT, 2, left-shift amount for the shifted immediate; 0 ≤ SHIFT < WIDTH
- CONST_VAL, 4, constant operand, truncated to WIDTH
- MEM_TIMEOUT, 15, maximum WAIT_MEM cycles without mem_valid; 0 = wait indefinitely
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- ALUSrcB  in  3  source select: 000 B, 001 CONST_VAL, 010 sext(imm)<<SHIFT, 011 sext(imm), 100 mem_data, 101–111 illegal
- load  in  1  capture request, sampled at the rising edge
- B  in  WIDTH  register-file B operand
- imm  in  IMM_W  instruction immediate
- mem_data  in  WIDTH  memory read data
- mem_valid  in  1  mem_data valid this cycle
- data_out  out  WIDTH  captured operand (registered)
- out_valid  out  1  one-cycle pulse, data_out updated at the preceding edge
- busy  out  1  waiting for memory data
- err  out  1  one-cycle pulse: illegal select or memory timeout

## Operation
- Sign extension: replicate imm[IMM_W-1] into bits WIDTH-1:IMM_W.
- Shifted immediate: sext(imm) << SHIFT, truncated to WIDTH; low SHIFT bits are 0.
- FSM states: IDLE, WAIT_MEM.
- IDLE with load=0: hold all registers; out_valid=0, err=0.
- IDLE, load=1, ALUSrcB in 000–011: capture the selected operand; out_valid=1 next cycle; stay IDLE.
- IDLE, load=1, ALUSrcB=100, mem_valid=1: capture mem_data immediately; out_valid=1; stay IDLE.
- IDLE, load=1, ALUSrcB=100, mem_valid=0: go to WAIT_MEM; clear the wait counter; data_out holds.
- IDLE, load=1, ALUSrcB in 101–111: err=1 next cycle; data_out holds; out_valid=0.
- WAIT_MEM, mem_valid=1: capture mem_data; out_valid=1; go to IDLE.
- WAIT_MEM, mem_valid=0: increment the counter.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT: err=1, data_out holds, go to IDLE.
- WAIT_MEM: load and ALUSrcB are ignored; the pending select is not re-sampled.
- Counter width: clog2(MEM_TIMEOUT+1), minimum 1.
- Simultaneous events: mem_valid on the same cycle the counter would time out wins (capture, no err).
- Back-to-back loads in IDLE are legal every cycle; each produces its own out_valid pulse.

## Timing
- Reset (asynchronous, immediate) clears everything: data_out=0, out_valid=0, busy=0, err=0, state=IDLE, counter=0.
- Reset mid-WAIT_MEM abandons the pending operand; no err is raised.
- Capture latency: data_out changes at the edge that samples load (or mem_valid); out_valid is high for the following cycle only.
- busy is registered: high exactly while state=WAIT_MEM, starting the cycle after the load edge.
- Timeout fires after exactly MEM_TIMEOUT WAIT_MEM cycles without mem_valid; err is high the cycle after.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset and basic selects:
  - Stimulus: reset, then load with ALUSrcB=000/001/010/011, B=0x12345678, imm=0x8001.
  - Response: data_out = 0x12345678, 0x00000004, 0xFFFE0004, 0xFFFF8001 in turn; out_valid pulses one cycle each; busy=0.
- Immediate memory capture: load, ALUSrcB=100, mem_valid=1, mem_data=0xDEADBEEF → data_out=0xDEADBEEF next edge, out_valid pulse, busy never set.
- Delayed memory capture:
  - Stimulus: load, ALUSrcB=100, mem_valid=0; assert mem_valid with mem_data=0xCAFEF00D three cycles later; toggle load and ALUSrcB while waiting.
  - Response: busy high 3 cycles; data_out unchanged until capture; then 0xCAFEF00D; out_valid pulses once.
- Timeout:
  - With MEM_TIMEOUT=15, hold mem_valid=0 → err pulses once after 15 WAIT_MEM cycles; data_out unchanged; state IDLE.
  - Repeat with mem_valid asserted on cycle 15 → capture, no err.
- Illegal select and reset mid-wait:
  - ALUSrcB=101 with load → err pulse; data_out unchanged.
  - Enter WAIT_MEM, then assert reset → all outputs 0 immediately; a subsequent load of 000 works normally.
- Parameter sweep: WIDTH=16, IMM_W=8, SHIFT=1, CONST_VAL=2, imm=0x80 → selects 010/011 give 0xFF00 and 0xFF80; select 001 gives 0x0002.
